// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl
//
// Sequencer for the RC4 key-search datapath. For each candidate key it runs
// the S-memory init engine, then the key-scheduled shuffle engine, then the
// message decrypt engine. It hands the shared memory router to one engine at
// a time and screens every decrypted byte. A candidate passes when every byte
// is a lowercase letter or a space and exactly MSG_LEN bytes arrived. A
// passing candidate stops the search. Otherwise the next key is tried until
// KEY_END has been checked.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   start          begin a search (ignored while busy)
//   abort          synchronous return to IDLE, overrides everything
//   init_start     1-cycle kick to the init engine
//   init_done      init engine completion pulse
//   shuffle_start  1-cycle kick to the shuffle engine
//   shuffle_done   shuffle engine completion pulse
//   decrypt_start  1-cycle kick to the decrypt engine
//   decrypt_done   decrypt engine completion pulse
//   char_valid     decrypted byte strobe
//   char_data      decrypted byte
//   mem_sel        router grant: 00 none, 01 init, 10 shuffle, 11 decrypt
//   secret_key     current candidate, zero-extended to KEY_WIDTH
//   busy           search in progress
//   found          plausible plaintext found
//   failed         search range exhausted
module rc4_key_search_ctrl #(
  parameter int                     KEY_WIDTH   = 24,
  parameter int                     SEARCH_BITS = 22,
  parameter logic [SEARCH_BITS-1:0] KEY_START   = '0,
  parameter logic [SEARCH_BITS-1:0] KEY_END     = 22'h3FFFFF,
  parameter int                     MSG_LEN     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 init_start,
  input  logic                 init_done,
  output logic                 shuffle_start,
  input  logic                 shuffle_done,
  output logic                 decrypt_start,
  input  logic                 decrypt_done,
  input  logic                 char_valid,
  input  logic [7:0]           char_data,
  output logic [1:0]           mem_sel,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic                 busy,
  output logic                 found,
  output logic                 failed
);

  // The counter must be able to hold MSG_LEN+1 so that an over-long message
  // stays distinguishable from an exact-length one.
  localparam int               CNT_W      = $clog2(MSG_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(MSG_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(MSG_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] SEL_NONE    = 2'b00;
  localparam logic [1:0] SEL_INIT    = 2'b01;
  localparam logic [1:0] SEL_SHUFFLE = 2'b10;
  localparam logic [1:0] SEL_DECRYPT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHUFFLE,
    DECRYPT,
    CHECK,
    FOUND,
    EXHAUSTED
  } state_t;

  state_t                 state;
  logic [SEARCH_BITS-1:0] key;
  logic                   reject;
  logic [CNT_W-1:0]       byte_count;
  logic                   byte_legal;

  assign byte_legal = (char_data == 8'h20) ||
                      ((char_data >= 8'h61) && (char_data <= 8'h7A));

  assign secret_key = {{(KEY_WIDTH - SEARCH_BITS){1'b0}}, key};

  // All outputs are registered. Each engine kick is set on the transition
  // into its state and cleared by default on the next edge, so it covers
  // exactly the first cycle of that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      key           <= KEY_START;
      reject        <= 1'b0;
      byte_count    <= '0;
      init_start    <= 1'b0;
      shuffle_start <= 1'b0;
      decrypt_start <= 1'b0;
      mem_sel       <= SEL_NONE;
      busy          <= 1'b0;
      found         <= 1'b0;
      failed        <= 1'b0;
    end else begin
      init_start    <= 1'b0;
      shuffle_start <= 1'b0;
      decrypt_start <= 1'b0;

      if (abort) begin
        // The key is kept so that a debugger can see where the search stopped.
        state   <= IDLE;
        mem_sel <= SEL_NONE;
        busy    <= 1'b0;
        found   <= 1'b0;
        failed  <= 1'b0;
      end else begin
        case (state)
          IDLE, FOUND, EXHAUSTED: begin
            if (start) begin
              state      <= INIT;
              key        <= KEY_START;
              reject     <= 1'b0;
              byte_count <= '0;
              init_start <= 1'b1;
              mem_sel    <= SEL_INIT;
              busy       <= 1'b1;
              found      <= 1'b0;
              failed     <= 1'b0;
            end
          end

          INIT: begin
            if (init_done) begin
              state         <= SHUFFLE;
              shuffle_start <= 1'b1;
              mem_sel       <= SEL_SHUFFLE;
            end
          end

          SHUFFLE: begin
            if (shuffle_done) begin
              state         <= DECRYPT;
              decrypt_start <= 1'b1;
              mem_sel       <= SEL_DECRYPT;
            end
          end

          DECRYPT: begin
            // A byte arriving on the same edge as decrypt_done still counts.
            if (char_valid) begin
              if (!byte_legal) begin
                reject <= 1'b1;
              end
              if (byte_count != CNT_SAT) begin
                byte_count <= byte_count + CNT_ONE;
              end
            end
            if (decrypt_done) begin
              state   <= CHECK;
              mem_sel <= SEL_NONE;
            end
          end

          CHECK: begin
            if (!reject && (byte_count == CNT_TARGET)) begin
              state <= FOUND;
              busy  <= 1'b0;
              found <= 1'b1;
            end else if (key == KEY_END) begin
              // Stopping here keeps the key from ever wrapping.
              state  <= EXHAUSTED;
              busy   <= 1'b0;
              failed <= 1'b1;
            end else begin
              state      <= INIT;
              key        <= key + SEARCH_BITS'(1);
              reject     <= 1'b0;
              byte_count <= '0;
              init_start <= 1'b1;
              mem_sel    <= SEL_INIT;
            end
          end

          default: begin
            state   <= IDLE;
            mem_sel <= SEL_NONE;
            busy    <= 1'b0;
            found   <= 1'b0;
            failed  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// tb_rc4_key_search_ctrl
//
// Directed bench for rc4_key_search_ctrl. The bench plays the three engines
// by hand: it raises the done pulses and the decrypted byte stream, and it
// checks the controller's outputs against hand-computed values. A second
// instance with KEY_START = KEY_END = 22'h3FFFFF covers the exhausted case.
// That instance shares every input except start. It sits in IDLE until it is
// started, so the shared done and byte strobes do not affect it.
module tb_rc4_key_search_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        abort = 1'b0;
  logic        init_done = 1'b0;
  logic        shuffle_done = 1'b0;
  logic        decrypt_done = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;

  logic        init_start, shuffle_start, decrypt_start;
  logic [1:0]  mem_sel;
  logic [23:0] secret_key;
  logic        busy, found, failed;

  logic        init_start2, shuffle_start2, decrypt_start2;
  logic [1:0]  mem_sel2;
  logic [23:0] secret_key2;
  logic        busy2, found2, failed2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rc4_key_search_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .init_start    (init_start),
    .init_done     (init_done),
    .shuffle_start (shuffle_start),
    .shuffle_done  (shuffle_done),
    .decrypt_start (decrypt_start),
    .decrypt_done  (decrypt_done),
    .char_valid    (char_valid),
    .char_data     (char_data),
    .mem_sel       (mem_sel),
    .secret_key    (secret_key),
    .busy          (busy),
    .found         (found),
    .failed        (failed)
  );

  rc4_key_search_ctrl #(
    .KEY_START (22'h3FFFFF),
    .KEY_END   (22'h3FFFFF)
  ) dut_end (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start2),
    .abort         (abort),
    .init_start    (init_start2),
    .init_done     (init_done),
    .shuffle_start (shuffle_start2),
    .shuffle_done  (shuffle_done),
    .decrypt_start (decrypt_start2),
    .decrypt_done  (decrypt_done),
    .char_valid    (char_valid),
    .char_data     (char_data),
    .mem_sel       (mem_sel2),
    .secret_key    (secret_key2),
    .busy          (busy2),
    .found         (found2),
    .failed        (failed2)
  );

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From INIT: init_done, then shuffle_done, ending in the first DECRYPT cycle.
  task automatic run_to_decrypt();
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    shuffle_done = 1'b1;
    step();
    shuffle_done = 1'b0;
  endtask

  // Send n bytes, with decrypt_done on the same edge as the last byte.
  task automatic send_bytes(input int n, input int bad_idx,
                            input logic [7:0] good_val, input logic [7:0] bad_val);
    for (int i = 0; i < n; i++) begin
      char_valid   = 1'b1;
      char_data    = (i == bad_idx) ? bad_val : good_val;
      decrypt_done = (i == n - 1);
      step();
    end
    char_valid   = 1'b0;
    decrypt_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    total++; if (init_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_init_start got=%b want=0", init_start); end
    total++; if (mem_sel !== 2'b00) begin bad++; $display("[TB] FAIL reset_mem_sel got=%b want=00", mem_sel); end
    total++; if ({busy, found, failed} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000", {busy, found, failed}); end
    total++; if (secret_key !== 24'h000000) begin bad++; $display("[TB] FAIL reset_key got=%h want=000000", secret_key); end
    total++; if (secret_key2 !== 24'h3FFFFF) begin bad++; $display("[TB] FAIL reset_key_end got=%h want=3fffff", secret_key2); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (init_start !== 1'b1) begin bad++; $display("[TB] FAIL start_init_pulse got=%b want=1", init_start); end
    total++; if (mem_sel !== 2'b01) begin bad++; $display("[TB] FAIL start_mem_sel got=%b want=01", mem_sel); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL start_busy got=%b want=1", busy); end
    total++; if (secret_key !== 24'h000000) begin bad++; $display("[TB] FAIL start_key got=%h want=000000", secret_key); end
    step();
    total++; if (init_start !== 1'b0) begin bad++; $display("[TB] FAIL init_pulse_width got=%b want=0", init_start); end
    total++; if (mem_sel !== 2'b01) begin bad++; $display("[TB] FAIL init_hold_sel got=%b want=01", mem_sel); end
  endtask

  task automatic test_found();
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    total++; if ({shuffle_start, mem_sel} !== 3'b110) begin bad++; $display("[TB] FAIL shuffle_entry got=%b want=110", {shuffle_start, mem_sel}); end
    shuffle_done = 1'b1;
    step();
    shuffle_done = 1'b0;
    total++; if ({decrypt_start, mem_sel} !== 3'b111) begin bad++; $display("[TB] FAIL decrypt_entry got=%b want=111", {decrypt_start, mem_sel}); end
    send_bytes(32, -1, 8'h61, 8'h00);
    total++; if ({mem_sel, busy, found} !== 4'b0010) begin bad++; $display("[TB] FAIL check_state got=%b want=0010", {mem_sel, busy, found}); end
    step();
    total++; if ({found, busy, mem_sel} !== 4'b1000) begin bad++; $display("[TB] FAIL found_flags got=%b want=1000", {found, busy, mem_sel}); end
    total++; if (secret_key !== 24'h000000) begin bad++; $display("[TB] FAIL found_key got=%h want=000000", secret_key); end
  endtask

  task automatic test_reject_advance();
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if ({init_start, found} !== 2'b10) begin bad++; $display("[TB] FAIL restart_from_found got=%b want=10", {init_start, found}); end
    run_to_decrypt();
    send_bytes(32, 5, 8'h61, 8'h41);
    step();
    total++; if ({init_start, mem_sel, found} !== 4'b1010) begin bad++; $display("[TB] FAIL advance_entry got=%b want=1010", {init_start, mem_sel, found}); end
    total++; if (secret_key !== 24'h000001) begin bad++; $display("[TB] FAIL advance_key got=%h want=000001", secret_key); end
    run_to_decrypt();
    send_bytes(32, -1, 8'h20, 8'h00);
    step();
    total++; if (found !== 1'b1) begin bad++; $display("[TB] FAIL spaces_found got=%b want=1", found); end
    total++; if (secret_key !== 24'h000001) begin bad++; $display("[TB] FAIL spaces_key got=%h want=000001", secret_key); end
  endtask

  task automatic test_stray_and_short();
    start = 1'b1;
    step();
    start = 1'b0;
    shuffle_done = 1'b1;
    step();
    shuffle_done = 1'b0;
    total++; if ({shuffle_start, mem_sel} !== 3'b001) begin bad++; $display("[TB] FAIL stray_shuffle_done got=%b want=001", {shuffle_start, mem_sel}); end
    run_to_decrypt();
    send_bytes(31, -1, 8'h7A, 8'h00);
    step();
    total++; if ({init_start, found} !== 2'b10) begin bad++; $display("[TB] FAIL short_msg_reject got=%b want=10", {init_start, found}); end
    total++; if (secret_key !== 24'h000001) begin bad++; $display("[TB] FAIL short_msg_key got=%h want=000001", secret_key); end
  endtask

  task automatic test_abort();
    run_to_decrypt();
    abort        = 1'b1;
    decrypt_done = 1'b1;
    char_valid   = 1'b1;
    char_data    = 8'h61;
    step();
    abort        = 1'b0;
    decrypt_done = 1'b0;
    char_valid   = 1'b0;
    total++; if ({mem_sel, busy, found, failed} !== 5'b00000) begin bad++; $display("[TB] FAIL abort_outputs got=%b want=00000", {mem_sel, busy, found, failed}); end
    total++; if ({init_start, shuffle_start, decrypt_start} !== 3'b000) begin bad++; $display("[TB] FAIL abort_pulses got=%b want=000", {init_start, shuffle_start, decrypt_start}); end
    total++; if (secret_key !== 24'h000001) begin bad++; $display("[TB] FAIL abort_key_kept got=%h want=000001", secret_key); end
    step();
    total++; if ({init_start, busy} !== 2'b00) begin bad++; $display("[TB] FAIL abort_stays_idle got=%b want=00", {init_start, busy}); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if ({init_start, secret_key} !== {1'b1, 24'h000000}) begin bad++; $display("[TB] FAIL abort_restart got=%h want=1000000", {init_start, secret_key}); end
  endtask

  task automatic test_async_reset();
    run_to_decrypt();
    send_bytes(1, 0, 8'h61, 8'h00);
    step();
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    total++; if ({shuffle_start, mem_sel, secret_key} !== {3'b110, 24'h000001}) begin bad++; $display("[TB] FAIL pre_reset_shuffle got=%h want=6000001", {shuffle_start, mem_sel, secret_key}); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if ({shuffle_start, mem_sel, busy} !== 4'b0000) begin bad++; $display("[TB] FAIL async_reset_outputs got=%b want=0000", {shuffle_start, mem_sel, busy}); end
    total++; if (secret_key !== 24'h000000) begin bad++; $display("[TB] FAIL async_reset_key got=%h want=000000", secret_key); end
    #1;
    reset_n = 1'b1;
    step();
    step();
    total++; if ({init_start, busy, mem_sel} !== 4'b0000) begin bad++; $display("[TB] FAIL no_auto_restart got=%b want=0000", {init_start, busy, mem_sel}); end
  endtask

  task automatic test_exhausted();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    total++; if ({init_start2, secret_key2} !== {1'b1, 24'h3FFFFF}) begin bad++; $display("[TB] FAIL end_start got=%h want=13fffff", {init_start2, secret_key2}); end
    run_to_decrypt();
    send_bytes(32, 0, 8'h61, 8'h7B);
    step();
    total++; if ({failed2, found2, busy2, mem_sel2} !== 5'b10000) begin bad++; $display("[TB] FAIL exhausted_flags got=%b want=10000", {failed2, found2, busy2, mem_sel2}); end
    total++; if (secret_key2 !== 24'h3FFFFF) begin bad++; $display("[TB] FAIL exhausted_key got=%h want=3fffff", secret_key2); end
    for (int i = 0; i < 3; i++) begin
      init_done = 1'b1;
      step();
      init_done = 1'b0;
      total++; if ({init_start2, shuffle_start2, decrypt_start2, failed2} !== 4'b0001) begin bad++; $display("[TB] FAIL exhausted_quiet got=%b want=0001", {init_start2, shuffle_start2, decrypt_start2, failed2}); end
    end
  endtask

  initial begin
    test_reset();
    test_start_pulse();
    test_found();
    test_reject_advance();
    test_stray_and_short();
    test_abort();
    test_async_reset();
    test_exhausted();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
